// File: rtl/onchip_ram_arbiter.sv
// rtl/onchip_ram_arbiter.sv - two-requester round-robin arbiter and sequencer for a single-port block RAM
//
// Clears the whole RAM after reset, then grants at most one request per cycle
// and returns read data to whichever requester issued the read.
//
// Ports
//   i_sys_clk, i_rst_n          clock (rising edge), asynchronous active-low reset
//   i_reqX_valid/o_reqX_ready   request handshake, X = 0/1; ready is combinational
//   i_reqX_we/addr/wdata        request command (1 = write), held while valid && !ready
//   o_rspX_valid/o_rspX_rdata   one-cycle read response; rdata holds between responses
//   o_init_done                 clear finished, requests are being accepted
//   o_ram_ena/wea/addra/dina    registered RAM command
//   i_ram_douta                 RAM read data, RD_LAT cycles after the ena cycle

module onchip_ram_arbiter #(
  parameter int                 ADDR_W     = 8,
  parameter int                 DATA_W     = 16,
  parameter int                 RD_LAT     = 1,
  parameter int                 INIT_CLEAR = 1,
  parameter logic [DATA_W-1:0]  CLR_VAL    = '0
) (
  input  logic              i_sys_clk,
  input  logic              i_rst_n,

  input  logic              i_req0_valid,
  output logic              o_req0_ready,
  input  logic              i_req0_we,
  input  logic [ADDR_W-1:0] i_req0_addr,
  input  logic [DATA_W-1:0] i_req0_wdata,
  output logic              o_rsp0_valid,
  output logic [DATA_W-1:0] o_rsp0_rdata,

  input  logic              i_req1_valid,
  output logic              o_req1_ready,
  input  logic              i_req1_we,
  input  logic [ADDR_W-1:0] i_req1_addr,
  input  logic [DATA_W-1:0] i_req1_wdata,
  output logic              o_rsp1_valid,
  output logic [DATA_W-1:0] o_rsp1_rdata,

  output logic              o_init_done,

  output logic              o_ram_ena,
  output logic              o_ram_wea,
  output logic [ADDR_W-1:0] o_ram_addra,
  output logic [DATA_W-1:0] o_ram_dina,
  input  logic [DATA_W-1:0] i_ram_douta
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              init_done_q, init_done_d;
  logic              last_grant_q, last_grant_d;

  logic              ram_ena_q, ram_ena_d;
  logic              ram_wea_q, ram_wea_d;
  logic [ADDR_W-1:0] ram_addra_q, ram_addra_d;
  logic [DATA_W-1:0] ram_dina_q, ram_dina_d;

  // Read-tracking pipe: bit 0 lines up with the RAM ena cycle, bit RD_LAT with valid douta.
  logic [RD_LAT:0]   pipe_rd_q, pipe_rd_d;
  logic [RD_LAT:0]   pipe_id_q, pipe_id_d;

  logic              rsp0_valid_q, rsp0_valid_d;
  logic [DATA_W-1:0] rsp0_rdata_q, rsp0_rdata_d;
  logic              rsp1_valid_q, rsp1_valid_d;
  logic [DATA_W-1:0] rsp1_rdata_q, rsp1_rdata_d;

  logic clr_active;
  logic clr_last;
  logic gnt0;
  logic gnt1;
  logic rd_issue;
  logic rsp_fire;
  logic rsp_id;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  assign clr_last = (clr_cnt_q == {ADDR_W{1'b1}});

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: begin
        if ((INIT_CLEAR == 0) || clr_last) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (clear sequencing, arbitration, RAM command)
  // ---------------------------------------------------------------------------
  assign clr_active = (state_q == ST_INIT) && (INIT_CLEAR != 0);

  // Arbitration is enabled by the registered done flag, so the FSM's first RUN
  // cycle (which carries the last clear write on the RAM bus) still grants
  // nothing and o_init_done rises only once the clear is fully on the bus.
  assign gnt0 = init_done_q && i_req0_valid && (!i_req1_valid || last_grant_q);
  assign gnt1 = init_done_q && i_req1_valid && (!i_req0_valid || !last_grant_q);

  assign o_req0_ready = gnt0;
  assign o_req1_ready = gnt1;

  always_comb begin
    clr_cnt_d    = '0;
    init_done_d  = 1'b0;
    last_grant_d = last_grant_q;
    ram_ena_d    = 1'b0;
    ram_wea_d    = 1'b0;
    ram_addra_d  = '0;
    ram_dina_d   = '0;

    // The counter wraps to 0 on the same edge the FSM leaves INIT.
    if (clr_active) begin
      clr_cnt_d = clr_cnt_q + ADDR_W'(1);
    end

    if (INIT_CLEAR != 0) begin
      init_done_d = (state_q == ST_RUN);
    end else begin
      init_done_d = (state_d == ST_RUN);
    end

    if (gnt0) begin
      last_grant_d = 1'b0;
    end else if (gnt1) begin
      last_grant_d = 1'b1;
    end

    if (clr_active) begin
      ram_ena_d   = 1'b1;
      ram_wea_d   = 1'b1;
      ram_addra_d = clr_cnt_q;
      ram_dina_d  = CLR_VAL;
    end else if (gnt0) begin
      ram_ena_d   = 1'b1;
      ram_wea_d   = i_req0_we;
      ram_addra_d = i_req0_addr;
      ram_dina_d  = i_req0_we ? i_req0_wdata : '0;
    end else if (gnt1) begin
      ram_ena_d   = 1'b1;
      ram_wea_d   = i_req1_we;
      ram_addra_d = i_req1_addr;
      ram_dina_d  = i_req1_we ? i_req1_wdata : '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Read tracking and response routing
  // ---------------------------------------------------------------------------
  assign rd_issue = (gnt0 && !i_req0_we) || (gnt1 && !i_req1_we);
  assign rsp_fire = pipe_rd_q[RD_LAT];
  assign rsp_id   = pipe_id_q[RD_LAT];

  always_comb begin
    pipe_rd_d    = {pipe_rd_q[RD_LAT-1:0], rd_issue};
    pipe_id_d    = {pipe_id_q[RD_LAT-1:0], gnt1};
    rsp0_valid_d = rsp_fire && !rsp_id;
    rsp1_valid_d = rsp_fire && rsp_id;
    rsp0_rdata_d = rsp0_rdata_q;
    rsp1_rdata_d = rsp1_rdata_q;
    if (rsp0_valid_d) begin
      rsp0_rdata_d = i_ram_douta;
    end
    if (rsp1_valid_d) begin
      rsp1_rdata_d = i_ram_douta;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      clr_cnt_q    <= '0;
      init_done_q  <= 1'b0;
      last_grant_q <= 1'b1;
      ram_ena_q    <= 1'b0;
      ram_wea_q    <= 1'b0;
      ram_addra_q  <= '0;
      ram_dina_q   <= '0;
      pipe_rd_q    <= '0;
      pipe_id_q    <= '0;
      rsp0_valid_q <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_valid_q <= 1'b0;
      rsp1_rdata_q <= '0;
    end else begin
      clr_cnt_q    <= clr_cnt_d;
      init_done_q  <= init_done_d;
      last_grant_q <= last_grant_d;
      ram_ena_q    <= ram_ena_d;
      ram_wea_q    <= ram_wea_d;
      ram_addra_q  <= ram_addra_d;
      ram_dina_q   <= ram_dina_d;
      pipe_rd_q    <= pipe_rd_d;
      pipe_id_q    <= pipe_id_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp1_rdata_q <= rsp1_rdata_d;
    end
  end

  assign o_init_done  = init_done_q;
  assign o_ram_ena    = ram_ena_q;
  assign o_ram_wea    = ram_wea_q;
  assign o_ram_addra  = ram_addra_q;
  assign o_ram_dina   = ram_dina_q;
  assign o_rsp0_valid = rsp0_valid_q;
  assign o_rsp0_rdata = rsp0_rdata_q;
  assign o_rsp1_valid = rsp1_valid_q;
  assign o_rsp1_rdata = rsp1_rdata_q;

endmodule

// File: doc/onchip_ram_arbiter.md
# onchip_ram_arbiter

Two-requester round-robin arbiter and sequencer in front of a single-port on-chip block RAM (ena/wea/addra/dina/douta). After reset it clears the whole RAM, then grants one request per cycle to either requester. It routes read data back to the requester that issued the read, with a fixed, parameterised latency. It sits between two client engines and the onchip_memory instance in single-port configuration, and makes the RAM look like two independent request/response ports.

## Interface
- ADDR_W, 8: RAM address width; depth = 2^ADDR_W.
- DATA_W, 16: RAM data width.
- RD_LAT, 1: RAM read latency in cycles, from the ena cycle to valid douta. Legal values are 1 and 2.
- INIT_CLEAR, 1: 1 means write CLR_VAL to every address after reset. 0 means skip the clear.
- CLR_VAL, 0: DATA_W-bit value written during the clear.

Ports:
- i_sys_clk  in  1  system clock; all logic is on its rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_req0_valid  in  1  requester 0 has a request.
- o_req0_ready  out  1  requester 0 is granted this cycle.
- i_req0_we  in  1  1 = write, 0 = read.
- i_req0_addr  in  ADDR_W  request address.
- i_req0_wdata  in  DATA_W  write data.
- o_rsp0_valid  out  1  read data valid, one-cycle pulse.
- o_rsp0_rdata  out  DATA_W  read data.
- i_req1_* / o_req1_ready / o_rsp1_*  same as requester 0, for requester 1.
- o_init_done  out  1  clear complete; the arbiter is accepting requests.
- o_ram_ena  out  1  RAM enable.
- o_ram_wea  out  1  RAM write enable.
- o_ram_addra  out  ADDR_W  RAM address.
- o_ram_dina  out  DATA_W  RAM write data.
- i_ram_douta  in  DATA_W  RAM read data.

## Operation
- The control FSM has two states, INIT and RUN. Reset enters INIT.
- INIT with INIT_CLEAR=1:
  - A clear counter runs 0..2^ADDR_W-1, one address per cycle, with o_ram_ena=o_ram_wea=1 and o_ram_dina=CLR_VAL.
  - After the write to the last address, the FSM moves to RUN.
  - Both o_reqX_ready are 0 throughout INIT.
- INIT with INIT_CLEAR=0: the FSM moves to RUN on the first clock edge after reset release.
- RUN: o_init_done=1. The FSM stays in RUN until reset.
- Arbitration in RUN:
  - o_reqX_ready is combinational from the valids and a registered last_grant pointer.
  - Only req0 valid: grant 0. Only req1 valid: grant 1.
  - Both valid: grant the requester that is not last_grant.
  - At most one ready is high per cycle.
  - A handshake is valid && ready at a rising edge. last_grant updates only on a handshake.
  - Requesters hold we/addr/wdata stable while valid && !ready.
- RAM command:
  - A handshake in cycle n drives o_ram_ena=1 in cycle n+1, with o_ram_wea=we, o_ram_addra=addr, o_ram_dina=wdata (0 for reads). All o_ram_* are registered.
  - Idle cycles: o_ram_ena=0, o_ram_wea=0; address and data hold 0.
- Read tracking:
  - A shift pipe of depth RD_LAT+1 carries {is_read, requester_id}.
  - The targeted requester gets o_rspX_valid=1 for one cycle, with o_rspX_rdata = i_ram_douta registered. o_rspX_rdata holds its value otherwise.
  - Writes produce no response.
  - Responses cannot be back-pressured.
- Ordering: commands reach the RAM in grant order. A read granted after a write to the same address returns the new data.

## Timing
- Throughput: one request per cycle in RUN, sustained, across either or both requesters.
- Read latency: handshake in cycle n gives o_rspX_valid in cycle n+2+RD_LAT (n+3 at RD_LAT=1).
- Clear duration: 2^ADDR_W cycles. o_init_done rises in the cycle after the last clear write, i.e. cycle 2^ADDR_W after the first clear cycle.
- Reset values:
  - All o_ram_*, o_reqX_ready, o_rspX_valid, o_rspX_rdata and o_init_done are 0.
  - last_grant = 1, so req0 wins the first tie.
  - The clear counter and the response pipe are 0.
- Reset asserted mid-operation:
  - All outputs return to their reset values immediately (asynchronously).
  - In-flight reads are discarded; no o_rspX_valid is issued for them.
  - INIT reruns after release.
- Boundaries:
  - Address 2^ADDR_W-1 is a legal request.
  - The clear counter wraps to 0 in the same cycle it transitions to RUN.
  - Back-to-back reads from both requesters interleave responses in grant order, one per cycle.

## Test plan
- Reset/clear (ADDR_W=8, INIT_CLEAR=1, CLR_VAL=16'h0000):
  - Release reset → 256 cycles of ena=wea=1 with addra 0..255, then o_init_done=1.
  - A subsequent read of addr 8'h7F returns 16'h0000.
- Single requester write/read:
  - req0 writes 16'hA55A to 8'h10, then reads 8'h10 → o_rsp0_valid exactly 3 cycles after the read handshake, rdata=16'hA55A.
  - o_rsp1_valid stays 0.
- Contention:
  - Both requesters are held valid for 8 reads, req0 at addr 8'h00+i and req1 at 8'h80+i → grants alternate 0,1,0,1… starting with 0.
  - Each response arrives at its requester with the correct data, one response per cycle.
- Write-then-read hazard:
  - req1 writes 16'h1234 to 8'hFF in cycle n, and req0 reads 8'hFF granted in cycle n+1 → o_rsp0_rdata=16'h1234.
- Reset mid-stream:
  - Assert i_rst_n=0 while 2 reads are in flight → no o_rspX_valid pulses appear, all outputs are 0 during reset, and the full clear sequence repeats after release.
- RD_LAT=2 build: the same single-requester read returns its response 4 cycles after the handshake.
